// File: rtl/upscale_2x_bilinear_pkg.sv
// Shared constants and state encoding for the 2x bilinear upsampler.
// Lane offsets locate each pixel of the 2x2 output block within the 32-bit word.
package upscale_pkg;

   localparam int unsigned PW      = 8;

   localparam int unsigned LANE_TL = 0;
   localparam int unsigned LANE_TR = 8;
   localparam int unsigned LANE_BL = 16;
   localparam int unsigned LANE_BR = 24;

   typedef enum logic [1:0] {
      S_FILL,
      S_RUN,
      S_EOL,
      S_FLUSH
   } state_t;

endpackage

// File: rtl/upscale_2x_bilinear_interp.sv
// Combinational 2x2 bilinear block from four corner pixels (a=TL, b=TR, c=BL, d=BR source).
// Sums are widened so the rounding add never overflows.
module upscale_interp_2x2
   import upscale_pkg::*;
(
   input  logic [PW-1:0]   i_a,
   input  logic [PW-1:0]   i_b,
   input  logic [PW-1:0]   i_c,
   input  logic [PW-1:0]   i_d,
   output logic [4*PW-1:0] o_block
);

   logic [PW:0]   w_sum_ab;
   logic [PW:0]   w_sum_ac;
   logic [PW+1:0] w_sum_all;

   always_comb begin
      w_sum_ab  = {1'b0, i_a} + {1'b0, i_b} + (PW+1)'(1);
      w_sum_ac  = {1'b0, i_a} + {1'b0, i_c} + (PW+1)'(1);
      w_sum_all = {2'b00, i_a} + {2'b00, i_b} + {2'b00, i_c} + {2'b00, i_d} + (PW+2)'(2);

      o_block                  = '0;
      o_block[LANE_TL +: PW]   = i_a;
      o_block[LANE_TR +: PW]   = PW'(w_sum_ab >> 1);
      o_block[LANE_BL +: PW]   = PW'(w_sum_ac >> 1);
      o_block[LANE_BR +: PW]   = PW'(w_sum_all >> 2);
   end

endmodule

// File: rtl/upscale_2x_bilinear.sv
// Streaming 2x bilinear upsampler: one line buffer, previous-column registers and a
// FILL/RUN/EOL/FLUSH FSM that emits one 2x2 block per input pixel in raster order.
module upscale_2x_bilinear
   import upscale_pkg::*;
#(
   parameter int unsigned WIDTH  = 128,
   parameter int unsigned HEIGHT = 128
)
(
   input  logic            clk,
   input  logic            rst,
   input  logic [PW-1:0]   din,
   input  logic            din_vld,
   output logic            din_rdy,
   output logic [4*PW-1:0] dout,
   output logic            dout_vld,
   output logic            frame_done
);

   localparam int unsigned     CW       = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
   localparam int unsigned     RW       = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
   localparam logic [CW-1:0]   COL_LAST = CW'(WIDTH - 1);
   localparam logic [RW-1:0]   ROW_LAST = RW'(HEIGHT - 1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [CW-1:0]     r_col;
   logic [RW-1:0]     r_row;
   logic [PW-1:0]     r_linebuf [WIDTH];
   logic [PW-1:0]     r_prev_top;
   logic [PW-1:0]     r_prev_bot;
   logic [4*PW-1:0]   r_dout;
   logic              r_dout_vld;
   logic              r_frame_done;

   logic              w_rdy;
   logic              w_accept;
   logic              w_col_last;
   logic              w_row_last;
   logic [CW-1:0]     w_nxt_idx;
   logic [PW-1:0]     w_lb_cur;
   logic [PW-1:0]     w_lb_nxt;
   logic [PW-1:0]     w_a;
   logic [PW-1:0]     w_b;
   logic [PW-1:0]     w_c;
   logic [PW-1:0]     w_d;
   logic [4*PW-1:0]   w_block;
   logic              w_emit;
   logic              w_last_blk;

   assign w_rdy      = (r_state == S_FILL) || (r_state == S_RUN);
   assign din_rdy    = w_rdy;
   assign w_accept   = din_vld && w_rdy;
   assign w_col_last = (r_col == COL_LAST);
   assign w_row_last = (r_row == ROW_LAST);

   // Right neighbour index clamps at the last column so the flush replicates it.
   assign w_nxt_idx  = w_col_last ? r_col : r_col + CW'(1);
   assign w_lb_cur   = r_linebuf[r_col];
   assign w_lb_nxt   = r_linebuf[w_nxt_idx];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_FILL;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_emit      = 1'b0;
      w_last_blk  = 1'b0;
      w_a         = r_prev_top;
      w_b         = r_prev_top;
      w_c         = r_prev_bot;
      w_d         = r_prev_bot;
      case (r_state)
         S_FILL: begin
            if (w_accept && w_col_last) begin
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            // Block (r-1,c-1): previous column from registers, current column from linebuf/din.
            w_b = w_lb_cur;
            w_d = din;
            if (w_accept) begin
               w_emit = (r_col != '0);
               if (w_col_last) begin
                  w_state_nxt = S_EOL;
               end
            end
         end
         S_EOL: begin
            w_emit      = 1'b1;
            w_state_nxt = w_row_last ? S_FLUSH : S_RUN;
         end
         S_FLUSH: begin
            w_a    = w_lb_cur;
            w_b    = w_lb_nxt;
            w_c    = w_lb_cur;
            w_d    = w_lb_nxt;
            w_emit = 1'b1;
            if (w_col_last) begin
               w_last_blk  = 1'b1;
               w_state_nxt = S_FILL;
            end
         end
         default: begin
            w_state_nxt = S_FILL;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_col      <= '0;
         r_row      <= '0;
         r_prev_top <= '0;
         r_prev_bot <= '0;
      end else begin
         case (r_state)
            S_FILL: begin
               if (w_accept) begin
                  if (w_col_last) begin
                     r_col <= '0;
                     r_row <= RW'(1);
                  end else begin
                     r_col <= r_col + CW'(1);
                  end
               end
            end
            S_RUN: begin
               if (w_accept) begin
                  r_prev_top <= w_lb_cur;
                  r_prev_bot <= din;
                  r_col      <= w_col_last ? '0 : r_col + CW'(1);
               end
            end
            S_EOL: begin
               r_row <= w_row_last ? '0 : r_row + RW'(1);
            end
            S_FLUSH: begin
               if (w_col_last) begin
                  r_col <= '0;
                  r_row <= '0;
               end else begin
                  r_col <= r_col + CW'(1);
               end
            end
            default: begin
               r_col <= '0;
               r_row <= '0;
            end
         endcase
      end
   end

   // Read-before-write: the async read above sees the previous row's pixel this cycle.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_linebuf[r_col] <= din;
      end
   end

   upscale_interp_2x2 u_interp (
      .i_a     (w_a),
      .i_b     (w_b),
      .i_c     (w_c),
      .i_d     (w_d),
      .o_block (w_block)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dout       <= '0;
         r_dout_vld   <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_dout_vld   <= w_emit;
         r_frame_done <= w_last_blk;
         if (w_emit) begin
            r_dout <= w_block;
         end
      end
   end

   assign dout       = r_dout;
   assign dout_vld   = r_dout_vld;
   assign frame_done = r_frame_done;

endmodule

// File: tb/tb_upscale_2x_bilinear.sv
// Directed bench for upscale_2x_bilinear: a 4x2 instance for hand-computed vectors
// and an 8x4 instance for gapped random frames checked against a reference model.
module tb_upscale_2x_bilinear;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst4 = 1'b1;
   logic [7:0]  din4 = '0;
   logic        vld4 = 1'b0;
   logic        rdy4;
   logic [31:0] dout4;
   logic        dvld4;
   logic        fd4;

   logic        rst8 = 1'b1;
   logic [7:0]  din8 = '0;
   logic        vld8 = 1'b0;
   logic        rdy8;
   logic [31:0] dout8;
   logic        dvld8;
   logic        fd8;

   upscale_2x_bilinear #(.WIDTH(4), .HEIGHT(2)) u_dut4 (
      .clk        (clk),
      .rst        (rst4),
      .din        (din4),
      .din_vld    (vld4),
      .din_rdy    (rdy4),
      .dout       (dout4),
      .dout_vld   (dvld4),
      .frame_done (fd4)
   );

   upscale_2x_bilinear #(.WIDTH(8), .HEIGHT(4)) u_dut8 (
      .clk        (clk),
      .rst        (rst8),
      .din        (din8),
      .din_vld    (vld8),
      .din_rdy    (rdy8),
      .dout       (dout8),
      .dout_vld   (dvld8),
      .frame_done (fd8)
   );

   int ncmp  = 0;
   int nfail = 0;

   logic [31:0] q4[$];
   logic [31:0] q8[$];
   int nfd4     = 0;
   int fd_idx4  = 0;
   int nlow4    = 0;
   int nfd_acc4 = 0;
   int nfd8     = 0;
   int nacc8    = 0;

   logic [7:0] img [4][8];

   always @(negedge clk) begin
      if (dvld4) q4.push_back(dout4);
      if (fd4) begin
         nfd4++;
         fd_idx4 = q4.size();
         if (vld4 && rdy4) nfd_acc4++;
      end
      if (!rdy4 && !rst4) nlow4++;
      if (dvld8) q8.push_back(dout8);
      if (fd8) nfd8++;
      if (vld8 && rdy8 && !rst8) nacc8++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] blk(input int a, input int b, input int c, input int d);
      int p01, p10, p11;
      p01 = (a + b + 1) / 2;
      p10 = (a + c + 1) / 2;
      p11 = (a + b + c + d + 2) / 4;
      return {8'(p11), 8'(p10), 8'(p01), 8'(a)};
   endfunction

   task automatic push4(input logic [7:0] p);
      int n;
      din4 = p;
      vld4 = 1'b1;
      n = 0;
      @(negedge clk);
      while (!rdy4 && n < 64) begin
         @(negedge clk);
         n++;
      end
      if (!rdy4) chk("push4_rdy_timeout", 32'(rdy4), 32'd1);
      @(posedge clk);
      #1;
      vld4 = 1'b0;
   endtask

   task automatic push8(input logic [7:0] p);
      int n;
      while ($urandom_range(1) == 1) begin
         @(posedge clk);
         #1;
      end
      din8 = p;
      vld8 = 1'b1;
      n = 0;
      @(negedge clk);
      while (!rdy8 && n < 64) begin
         @(negedge clk);
         n++;
      end
      if (!rdy8) chk("push8_rdy_timeout", 32'(rdy8), 32'd1);
      @(posedge clk);
      #1;
      vld8 = 1'b0;
   endtask

   task automatic wait_fd4(input int exp);
      for (int k = 0; k < 200 && nfd4 < exp; k++) @(negedge clk);
      repeat (3) @(negedge clk);
      chk("fd4_count", 32'(nfd4), 32'(exp));
      @(posedge clk);
      #1;
   endtask

   task automatic wait_fd8(input int exp);
      for (int k = 0; k < 400 && nfd8 < exp; k++) @(negedge clk);
      repeat (3) @(negedge clk);
      chk("fd8_count", 32'(nfd8), 32'(exp));
      @(posedge clk);
      #1;
   endtask

   task automatic clear4();
      q4.delete();
      nfd4 = 0;
      fd_idx4 = 0;
      nlow4 = 0;
      nfd_acc4 = 0;
   endtask

   task automatic clear8();
      q8.delete();
      nfd8 = 0;
      nacc8 = 0;
   endtask

   task automatic fill_img();
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 8; c++)
            img[r][c] = 8'($urandom_range(255));
   endtask

   task automatic check_frame8(input string tag);
      int r1, c1;
      chk({tag, "_blocks"}, 32'(q8.size()), 32'd32);
      chk({tag, "_accepts"}, 32'(nacc8), 32'd32);
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 8; c++) begin
            r1 = (r == 3) ? r : r + 1;
            c1 = (c == 7) ? c : c + 1;
            chk($sformatf("%s_blk_r%0d_c%0d", tag, r, c), q8[r*8 + c],
                blk(int'(img[r][c]), int'(img[r][c1]), int'(img[r1][c]), int'(img[r1][c1])));
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst4_dout", dout4, 32'h0);
      chk("rst4_dvld", 32'(dvld4), 32'd0);
      chk("rst4_fd", 32'(fd4), 32'd0);
      chk("rst4_rdy", 32'(rdy4), 32'd1);
      chk("rst8_dout", dout8, 32'h0);
      chk("rst8_rdy", 32'(rdy8), 32'd1);
      @(posedge clk);
      #1;
      rst4 = 1'b0;
      rst8 = 1'b0;
      @(posedge clk);
      #1;
      clear4();
      clear8();

      // Constant frame, continuous valid
      for (int i = 0; i < 8; i++) push4(8'd100);
      wait_fd4(1);
      chk("const_blocks", 32'(q4.size()), 32'd8);
      for (int i = 0; i < 8; i++) chk($sformatf("const_blk%0d", i), q4[i], 32'h64646464);
      chk("const_fd_beat", 32'(fd_idx4), 32'd8);
      chk("const_rdy_low", 32'(nlow4), 32'd5);

      // Ramp frame
      clear4();
      for (int c = 0; c < 4; c++) push4(8'(c * 10));
      for (int c = 0; c < 4; c++) push4(8'(40 + c * 10));
      wait_fd4(1);
      chk("ramp_blocks", 32'(q4.size()), 32'd8);
      chk("ramp_b00", q4[0], 32'h19140500);
      chk("ramp_b01", q4[1], 32'h231E0F0A);
      chk("ramp_b03_eol", q4[3], 32'h32321E1E);
      chk("ramp_b10_flush", q4[4], 32'h2D282D28);
      chk("ramp_b13_flush", q4[7], 32'h46464646);

      // Rounding
      clear4();
      push4(8'd255);
      for (int i = 0; i < 7; i++) push4(8'd0);
      wait_fd4(1);
      chk("round_b00", q4[0], 32'h408080FF);
      chk("round_b13", q4[7], 32'h00000000);

      // Back-to-back frames
      clear4();
      for (int c = 0; c < 4; c++) push4(8'(c * 10));
      for (int c = 0; c < 4; c++) push4(8'(40 + c * 10));
      for (int i = 0; i < 8; i++) push4(8'd7);
      wait_fd4(2);
      chk("b2b_blocks", 32'(q4.size()), 32'd16);
      chk("b2b_f0_b00", q4[0], 32'h19140500);
      chk("b2b_f1_b00", q4[8], 32'h07070707);
      chk("b2b_f1_b13", q4[15], 32'h07070707);
      chk("b2b_accept_after_flush", 32'(nfd_acc4), 32'd1);

      // Random gaps on the 8x4 instance
      clear8();
      fill_img();
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 8; c++)
            push8(img[r][c]);
      wait_fd8(1);
      check_frame8("gap");

      // Reset during row 2, then a fresh frame
      fill_img();
      for (int i = 0; i < 19; i++) push8(img[i / 8][i % 8]);
      rst8 = 1'b1;
      #1;
      chk("midrst_dout", dout8, 32'h0);
      chk("midrst_dvld", 32'(dvld8), 32'd0);
      chk("midrst_fd", 32'(fd8), 32'd0);
      chk("midrst_rdy", 32'(rdy8), 32'd1);
      clear8();
      repeat (2) @(posedge clk);
      #1;
      rst8 = 1'b0;
      @(posedge clk);
      #1;
      fill_img();
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 8; c++)
            push8(img[r][c]);
      wait_fd8(1);
      check_frame8("postrst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
